// File: rtl/seq_responder_pkg.sv
// rtl/seq_responder_pkg.sv - shared types, defaults and delay clamp for seq_responder
//
// Contents:
//   state_e     : responder FSM states (idle, delay wait, c pulse, b pulse)
//   MAX_DLY_DEF : default maximum request-to-c delay in cycles
//   DLY_W_DEF   : default width of the requested delay field
//   clamp_dly() : maps a raw requested delay onto 1..max_dly
package seq_responder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_C    = 2'd2,
    ST_B    = 2'd3
  } state_e;

  localparam int MAX_DLY_DEF = 5;
  localparam int DLY_W_DEF   = 3;

  // A zero delay is treated as the shortest legal one; oversize requests
  // saturate rather than wrap.
  function automatic int clamp_dly(input int dly, input int max_dly);
    if (dly < 1) return 1;
    if (dly > max_dly) return max_dly;
    return dly;
  endfunction

endpackage

// File: rtl/seq_responder_if.sv
// rtl/seq_responder_if.sv - request/completion bundle between initiator and seq_responder
//
// Signals:
//   a    : request strobe (initiator -> responder), valid only with ce
//   ce   : enable, held high from request through b
//   dly  : requested a->c delay, sampled with a
//   c    : one-cycle completion pulse
//   b    : one-cycle pulse the cycle after c
//   busy : sequence in progress
//   err  : one-cycle abort pulse
//   ovf  : sticky dropped-request flag
// Modports: master (initiator side), slave (responder side).
interface seq_responder_if #(
  parameter int DLY_W = 3
);
  logic             a;
  logic             ce;
  logic [DLY_W-1:0] dly;
  logic             c;
  logic             b;
  logic             busy;
  logic             err;
  logic             ovf;

  modport master (
    output a, ce, dly,
    input  c, b, busy, err, ovf
  );

  modport slave (
    input  a, ce, dly,
    output c, b, busy, err, ovf
  );
endinterface

// File: rtl/seq_responder_pend.sv
// rtl/seq_responder_pend.sv - one-deep pending-request holding register
//
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   i_push     : store a request (with i_dly) into the slot
//   i_pop      : consume the held request this edge
//   i_flush    : discard the held request (takes priority)
//   i_dly      : clamped delay of the request being pushed
//   o_valid    : slot holds a request
//   o_dly      : delay of the held request
//   o_ovf      : strobe, a push was dropped because the slot stayed full
module seq_responder_pend #(
  parameter int DLY_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic             i_flush,
  input  logic [DLY_W-1:0] i_dly,
  output logic             o_valid,
  output logic [DLY_W-1:0] o_dly,
  output logic             o_ovf
);
  logic             r_valid;
  logic [DLY_W-1:0] r_dly;

  // A push on the same edge as a pop replaces the departing entry, so it
  // is only dropped when the slot is full and not draining.
  assign o_ovf   = i_push & r_valid & ~i_pop & ~i_flush;
  assign o_valid = r_valid;
  assign o_dly   = r_dly;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_dly   <= '0;
    end else if (i_flush) begin
      r_valid <= 1'b0;
    end else if (i_push && (!r_valid || i_pop)) begin
      r_valid <= 1'b1;
      r_dly   <= i_dly;
    end else if (i_pop) begin
      r_valid <= 1'b0;
    end
  end
endmodule

// File: rtl/seq_responder.sv
// rtl/seq_responder.sv - responder for the a/ce -> c -> b handshake with one pending slot
//
// Parameters:
//   MAX_DLY : maximum a->c delay in cycles (>= 1)
//   DLY_W   : width of dly, 2**DLY_W > MAX_DLY
// Ports:
//   clk   : clock, posedge
//   rst_n : asynchronous active-low reset
//   bus   : seq_responder_if.slave (a, ce, dly in; c, b, busy, err, ovf out)
// Optional: define SEQ_RESPONDER_SVA_EN to compile embedded assertions.
module seq_responder
  import seq_responder_pkg::*;
#(
  parameter int MAX_DLY = MAX_DLY_DEF,
  parameter int DLY_W   = DLY_W_DEF
) (
  input logic             clk,
  input logic             rst_n,
  seq_responder_if.slave  bus
);
  localparam logic [DLY_W-1:0] ONE = DLY_W'(1);
  localparam logic [DLY_W-1:0] TWO = DLY_W'(2);

  state_e           r_state;
  logic [DLY_W-1:0] r_cnt;
  logic             r_c;
  logic             r_b;
  logic             r_busy;
  logic             r_err;
  logic             r_ovf;

  logic             w_req;
  logic [DLY_W-1:0] w_d;
  logic             w_in_seq;
  logic             w_abort;
  logic             w_in_b;
  logic             w_pend_valid;
  logic [DLY_W-1:0] w_pend_dly;
  logic             w_pend_ovf;
  logic             w_push;
  logic             w_pop;
  logic             w_start;
  logic [DLY_W-1:0] w_start_dly;

  assign w_req    = bus.a & bus.ce;
  assign w_d      = DLY_W'(clamp_dly(int'(bus.dly), MAX_DLY));
  assign w_in_seq = (r_state != ST_IDLE);
  assign w_abort  = w_in_seq & ~bus.ce;
  assign w_in_b   = (r_state == ST_B);

  // In B the held request (if any) starts now; a new request arriving in B
  // with an empty slot starts directly instead of being parked.
  assign w_pop  = w_in_b & bus.ce & w_pend_valid;
  assign w_push = w_req & w_in_seq & ~(w_in_b & ~w_pend_valid);

  assign w_start     = ((r_state == ST_IDLE) & w_req) | (w_in_b & (w_pend_valid | w_req));
  assign w_start_dly = (w_in_b && w_pend_valid) ? w_pend_dly : w_d;

  seq_responder_pend #(
    .DLY_W (DLY_W)
  ) u_pend (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (w_abort),
    .i_dly   (w_d),
    .o_valid (w_pend_valid),
    .o_dly   (w_pend_dly),
    .o_ovf   (w_pend_ovf)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_c     <= 1'b0;
      r_b     <= 1'b0;
      r_busy  <= 1'b0;
      r_err   <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_c   <= 1'b0;
      r_b   <= 1'b0;
      r_err <= 1'b0;
      if (w_pend_ovf) r_ovf <= 1'b1;

      if (w_abort) begin
        r_state <= ST_IDLE;
        r_cnt   <= '0;
        r_busy  <= 1'b0;
        r_err   <= 1'b1;
      end else begin
        case (r_state)
          ST_IDLE, ST_B: begin
            if (w_start) begin
              r_cnt  <= w_start_dly;
              r_busy <= 1'b1;
              // c is registered one edge before it is sampled, so a delay
              // of one means c rises on the request edge itself.
              if (w_start_dly == ONE) begin
                r_state <= ST_C;
                r_c     <= 1'b1;
              end else begin
                r_state <= ST_WAIT;
              end
            end else begin
              r_state <= ST_IDLE;
              r_cnt   <= '0;
              r_busy  <= 1'b0;
            end
          end
          ST_WAIT: begin
            r_cnt <= r_cnt - ONE;
            if (r_cnt <= TWO) begin
              r_state <= ST_C;
              r_c     <= 1'b1;
            end
          end
          ST_C: begin
            r_state <= ST_B;
            r_b     <= 1'b1;
          end
          default: begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.c    = r_c;
  assign bus.b    = r_b;
  assign bus.busy = r_busy;
  assign bus.err  = r_err;
  assign bus.ovf  = r_ovf;

`ifdef SEQ_RESPONDER_SVA_EN
  a_c_b_exclusive: assert property (@(posedge clk) disable iff (!rst_n)
    !(r_c && r_b));

  a_err_quiet: assert property (@(posedge clk) disable iff (!rst_n)
    r_err |-> (!r_c && !r_b));

  a_seq_done: assert property (@(posedge clk) disable iff (!rst_n)
    (r_state == ST_IDLE && w_req) |->
      (bus.ce throughout (##[1:MAX_DLY] r_c ##1 r_b)) or (##[1:MAX_DLY+2] r_err));
`endif

endmodule

// File: doc/seq_responder.md
# seq_responder

Responder end of the a/ce → c → b handshake. It accepts a request pulse `a` qualified by enable `ce`, waits a per-request programmable delay of 1..MAX_DLY cycles, then drives a one-cycle `c` pulse followed on the next cycle by a one-cycle `b` pulse. It aborts cleanly if `ce` drops mid-sequence. It holds one pending request while busy and reports overflow and abort events. It sits between a request initiator and any logic that consumes the c/b completion pair.

## Interface
Parameters:
- `MAX_DLY`, default 5: maximum a→c delay in cycles; must be ≥1.
- `DLY_W`, default 3: width of `dly`; must satisfy 2^DLY_W > MAX_DLY.

Ports:
- `clk`, input, 1: single clock; all logic is on posedge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `a`, input, 1: request strobe, sampled only when `ce`=1.
- `ce`, input, 1: enable; must stay high from the request edge through the `b` edge.
- `dly`, input, DLY_W: requested a→c delay, sampled together with `a`.
- `c`, output, 1: registered one-cycle pulse.
- `b`, output, 1: registered one-cycle pulse, asserted the cycle after `c`.
- `busy`, output, 1: high while a sequence is in progress (states WAIT, C, B).
- `err`, output, 1: registered one-cycle pulse on abort.
- `ovf`, output, 1: sticky; set when a request is dropped. Cleared only by reset.

## Operation
- FSM states:
  - IDLE: no sequence in progress.
  - WAIT: delay counter running.
  - C: `c` is high.
  - B: `b` is high.
- Delay clamp applied at sampling:
  - `dly`=0 → 1.
  - `dly`>MAX_DLY → MAX_DLY.
  - The clamped value is d.
- IDLE, edge with `a`&`ce`: load counter with d.
  - If d=1, go straight to C.
  - Otherwise go to WAIT.
- WAIT: decrement the counter each edge; enter C so that `c` is high at exactly edge N+d, where N is the request edge.
- C → B unconditionally (if `ce`=1); `b` is high at edge N+d+1.
- B: if the pending slot is valid, start the pending request as if it were sampled at this edge. Otherwise go to IDLE.
- Request while busy (`a`&`ce` in WAIT/C/B):
  - Pending slot empty: store the request and its clamped delay.
  - Pending slot full: drop the request and set `ovf`.
- Abort: `ce`=0 at any edge while the state is not IDLE:
  - Clear `c` and `b` at that edge.
  - Flush the pending slot.
  - Pulse `err` for one cycle.
  - Go to IDLE.
- `a` with `ce`=0 is ignored in every state; it never sets `ovf`.

## Timing
- Reset values:
  - state=IDLE.
  - `c`=0, `b`=0, `busy`=0, `err`=0, `ovf`=0.
  - Pending slot empty, counter=0.
- Latency:
  - Request edge N → `c` sampled high at edge N+d, `b` at edge N+d+1.
  - `c` and `b` are each high for exactly one sampled edge and never overlap.
- `busy` rises at edge N and falls at edge N+d+1 unless a pending request is chained.
- Back-to-back chaining: a pending request with delay d2 gives `c` at edge N+d+1+d2. The `b`→pending-`c` gap is therefore d2 cycles.
- Simultaneous events in B with `ce`=1:
  - A new `a` is accepted into the pending slot; the slot frees at this same edge.
  - The accepted request therefore chains.
- Simultaneous abort and `a` (`ce`=0): abort wins and `a` is ignored.
- Reset mid-sequence: all state clears immediately, with no `err` pulse.

## Configuration
- Macro: `SEQ_RESPONDER_SVA_EN`.
- Defined: embedded concurrent assertions are compiled in:
  - Each accepted IDLE request satisfies ce throughout (##[1:MAX_DLY] c ##1 b) or produces `err`.
  - `c` and `b` are never simultaneously high.
  - `err` implies `c` and `b` are low.
- Undefined: no assertion code. Functional behavior is identical in both cases.

## Structure
- Package `seq_responder_pkg` holds:
  - The state enum (IDLE, WAIT, C, B).
  - The default `MAX_DLY` constant.
  - The delay-clamp function.
- Sub-module `seq_responder_pend`: one-deep pending-request holding register.
  - Inputs: push, pop, flush, delay in.
  - Outputs: valid, delay out, overflow strobe.

## Test plan
- Single request, `a`=1, `dly`=3, `ce`=1 at edge 2 → `c` at edge 5, `b` at edge 6, `busy` edges 2–5, `err`=0.
- Delay clamping:
  - `dly`=0 → `c` one edge after the request.
  - `dly`=7 with MAX_DLY=5 → `c` five edges after the request.
- Chaining:
  - First request at edge 2 with `dly`=2; second at edge 3 with `dly`=1.
  - Expected: `c`@4, `b`@5, `c`@6, `b`@7; `busy` continuous.
- Overflow: three requests at edges 2, 3, 4 with `dly`=5 → third dropped, `ovf`=1 from edge 4, only two c/b pairs.
- Abort: request at edge 2 with `dly`=4, `ce`=0 at edge 4 → no `c`/`b`, `err` pulse after edge 4, pending flushed, IDLE.
- Reset: `rst_n` asserted low while in WAIT → all outputs 0 asynchronously; after release, a request with `dly`=1 gives `c` one edge later.
